// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into words, writes them to
// instruction memory, and holds the core in reset until the requested count is loaded.
module imem_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_num_words,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [ADDR_WIDTH-1:0] i_cpu_pc,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    output logic                  o_cpu_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_byte_cnt;
    logic [ADDR_WIDTH-1:0] r_word_cnt;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_asm;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;

    logic w_can_start;
    logic w_legal;
    logic w_start_ok;
    logic w_start_bad;
    logic w_accept;
    logic w_last_byte;
    logic w_last_word;

    assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_legal     = (i_num_words != '0) && (i_num_words <= MAX_WORDS);
    assign w_start_ok  = w_can_start && i_start && w_legal;
    assign w_start_bad = w_can_start && i_start && !w_legal;
    assign w_accept    = (r_state == S_RECV) && i_byte_valid;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    // Compared in ADDR_WIDTH+1 bits so a full-memory count never needs word_cnt to wrap.
    assign w_last_word = ({1'b0, r_word_cnt} == (r_count - 1'b1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next_state = S_RECV;
            S_RECV:  if (w_accept && w_last_byte) w_next_state = S_WRITE;
            S_WRITE: w_next_state = w_last_word ? S_DONE : S_RECV;
            S_DONE:  if (w_start_ok) w_next_state = S_RECV;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = 1'b0;
        o_mem_we     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_cpu_rst    = 1'b1;
        case (r_state)
            S_RECV: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
            S_WRITE: begin
                o_mem_we = 1'b1;
                o_busy   = 1'b1;
            end
            S_DONE: begin
                o_done    = 1'b1;
                o_cpu_rst = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_count    <= '0;
            r_asm      <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_ok) begin
                r_count    <= i_num_words;
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
                r_asm      <= '0;
            end
            if (w_accept) begin
                r_asm[{r_byte_cnt, 3'b000} +: 8] <= i_byte;
                r_byte_cnt                       <= r_byte_cnt + 2'd1;
                // Write-port registers load only here so they hold outside WRITE.
                if (w_last_byte) begin
                    r_waddr <= r_word_cnt;
                    r_wdata <= {i_byte, r_asm[DATA_WIDTH-9:0]};
                end
            end
            if ((r_state == S_WRITE) && !w_last_word) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign o_mem_waddr = r_waddr;
    assign o_mem_wdata = r_wdata;
    assign o_err       = r_err;
    assign o_mem_raddr = o_cpu_rst ? '0 : i_cpu_pc;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; memory writes are checked against a
// scoreboard of expected {address, word} pairs filled as bytes are driven.
module tb_imem_boot_loader;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [AW:0]   i_num_words;
    logic          i_byte_valid;
    logic [7:0]    i_byte;
    logic          o_byte_ready;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_waddr;
    logic [DW-1:0] o_mem_wdata;
    logic [AW-1:0] i_cpu_pc;
    logic [AW-1:0] o_mem_raddr;
    logic          o_cpu_rst;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    imem_boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_words(i_num_words),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
        .o_mem_we(o_mem_we), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
        .i_cpu_pc(i_cpu_pc), .o_mem_raddr(o_mem_raddr), .o_cpu_rst(o_cpu_rst),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write is popped and compared; a write with nothing expected is an error.
    always @(negedge i_clk) begin
        if (!i_rst && o_mem_we) begin
            wr_t e;
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            chk("ready_in_write", 64'(o_byte_ready), 64'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("waddr", 64'(o_mem_waddr), 64'(e.addr));
                chk("wdata", 64'(o_mem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Hold the byte until a handshake is seen; valid stays high afterwards.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 0;
        int n   = 0;
        if (gaps) begin
            int g = $urandom_range(0, 2);
            i_byte_valid = 1'b0;
            for (int i = 0; i < g; i++) tick();
        end
        i_byte_valid = 1'b1;
        i_byte       = b;
        while (!acc && n < 20) begin
            acc = o_byte_ready;
            tick();
            n++;
        end
        if (!acc) chk("byte_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
        sb.push_back('{addr: a, data: w});
    endtask

    task automatic start(input logic [AW:0] n);
        i_start     = 1'b1;
        i_num_words = n;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        i_byte_valid = 1'b0;
        while (!o_done && n < 20) begin
            tick();
            n++;
        end
        chk("done_reached", 64'(o_done), 64'd1);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_num_words = '0;
        i_byte_valid = 1'b0; i_byte = '0; i_cpu_pc = 8'h10;

        // Reset then idle
        tick(); tick();
        chk("rst_cpu_rst", 64'(o_cpu_rst), 64'd1);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_we", 64'(o_mem_we), 64'd0);
        chk("rst_ready", 64'(o_byte_ready), 64'd0);
        chk("rst_raddr", 64'(o_mem_raddr), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_waddr", 64'(o_mem_waddr), 64'd0);
        chk("rst_wdata", 64'(o_mem_wdata), 64'd0);
        i_rst = 1'b0;
        tick();

        // Single-word load: write appears the cycle after the 4th byte
        start(9'd1);
        chk("sw_busy", 64'(o_busy), 64'd1);
        chk("sw_ready", 64'(o_byte_ready), 64'd1);
        send_word(8'h00, 32'h0000_0013, 1'b0);
        chk("sw_we_latency", 64'(o_mem_we), 64'd1);
        chk("sw_waddr_now", 64'(o_mem_waddr), 64'd0);
        chk("sw_wdata_now", 64'(o_mem_wdata), 64'h13);
        i_byte_valid = 1'b0;
        tick();
        chk("sw_we_pulse", 64'(o_mem_we), 64'd0);
        chk("sw_done", 64'(o_done), 64'd1);
        chk("sw_cpu_rst", 64'(o_cpu_rst), 64'd0);
        chk("sw_raddr", 64'(o_mem_raddr), 64'h10);
        chk("sw_busy_done", 64'(o_busy), 64'd0);
        chk("sw_wdata_hold", 64'(o_mem_wdata), 64'h13);
        i_cpu_pc = 8'h5A;
        #1 chk("sw_raddr_follow", 64'(o_mem_raddr), 64'h5A);

        // Multi-word with random gaps
        start(9'd3);
        chk("mw_done_clr", 64'(o_done), 64'd0);
        chk("mw_raddr_forced", 64'(o_mem_raddr), 64'd0);
        send_word(8'd0, 32'hDEAD_BEEF, 1'b1);
        send_word(8'd1, 32'h0102_0304, 1'b1);
        send_word(8'd2, 32'hA5C3_7E11, 1'b1);
        wait_done();
        chk("mw_sb_empty", 64'(sb.size()), 64'd0);

        // Illegal counts from DONE and from IDLE
        start(9'd0);
        chk("ill0_err", 64'(o_err), 64'd1);
        chk("ill0_done_kept", 64'(o_done), 64'd1);
        tick();
        chk("ill0_err_pulse", 64'(o_err), 64'd0);
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        start(9'd257);
        chk("ill257_err", 64'(o_err), 64'd1);
        chk("ill257_busy", 64'(o_busy), 64'd0);
        chk("ill257_ready", 64'(o_byte_ready), 64'd0);
        chk("ill257_cpu_rst", 64'(o_cpu_rst), 64'd1);
        tick();
        chk("ill257_err_pulse", 64'(o_err), 64'd0);
        chk("ill257_idle", 64'(o_busy), 64'd0);

        // Full memory: 256 words, last address 0xFF, no extra write
        start(9'd256);
        for (int i = 0; i < 256; i++) send_word(AW'(i), $urandom, 1'b0);
        chk("full_last_waddr", 64'(o_mem_waddr), 64'hFF);
        wait_done();
        tick(); tick();
        chk("full_still_done", 64'(o_done), 64'd1);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);

        // Abort after 2 of 4 words, then a fresh 2-word load
        start(9'd4);
        send_word(8'd0, 32'h1111_2222, 1'b0);
        send_word(8'd1, 32'h3333_4444, 1'b0);
        i_byte_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_cpu_rst", 64'(o_cpu_rst), 64'd1);
        chk("abort_done", 64'(o_done), 64'd0);
        chk("abort_ready", 64'(o_byte_ready), 64'd0);
        start(9'd2);
        send_word(8'd0, 32'hCAFE_F00D, 1'b1);
        send_word(8'd1, 32'h89AB_CDEF, 1'b1);
        wait_done();
        chk("restart_cpu_rst_low", 64'(o_cpu_rst), 64'd0);
        start(9'd1);
        chk("redo_cpu_rst", 64'(o_cpu_rst), 64'd1);
        chk("redo_done_clr", 64'(o_done), 64'd0);
        chk("redo_busy", 64'(o_busy), 64'd1);
        tick(); tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time controller that fills the instruction memory from an external byte stream (UART/debug link) and holds the core in reset while it does so.
- Assembles incoming bytes into little-endian 32-bit words.
- Sequences one write per word into the instruction memory write port.
- Multiplexes the memory read address between the loader (forced 0) and the core PC.
- Releases the core once the programmed word count has been written.

Parameters:
DATA_WIDTH, 32, instruction word width (fixed at 4 bytes).
ADDR_WIDTH, 8, word-address width of the instruction memory (2**ADDR_WIDTH words).

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_start  input  1  begin a load session (sampled in IDLE/DONE only)
i_num_words  input  ADDR_WIDTH+1  number of words to load, legal 1..2**ADDR_WIDTH
i_byte_valid  input  1  byte stream valid
i_byte  input  8  byte stream data
o_byte_ready  output  1  loader can accept a byte
o_mem_we  output  1  instruction memory write enable (1-cycle pulse per word)
o_mem_waddr  output  ADDR_WIDTH  word write address
o_mem_wdata  output  DATA_WIDTH  assembled word
i_cpu_pc  input  ADDR_WIDTH  core fetch word address
o_mem_raddr  output  ADDR_WIDTH  read address to instruction memory
o_cpu_rst  output  1  holds core in reset while high
o_busy  output  1  load session in progress (RECV or WRITE)
o_done  output  1  level, last load completed successfully
o_err  output  1  1-cycle pulse, illegal i_num_words on start

Behaviour:
- Reset (i_rst=1 at clock edge): state=IDLE, byte_cnt=0, word_cnt=0, assembly reg=0. Outputs: o_cpu_rst=1, o_byte_ready=0, o_mem_we=0, o_mem_waddr=0, o_mem_wdata=0, o_busy=0, o_done=0, o_err=0.
- Reset mid-session aborts immediately. Already-written words are not cleared. o_done returns to 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - o_cpu_rst=1.
  - i_start with 1 <= i_num_words <= 2**ADDR_WIDTH: latch count; clear byte_cnt, word_cnt and the assembly reg; go to RECV.
  - i_start with i_num_words=0 or >2**ADDR_WIDTH: o_err=1 for exactly the next cycle; stay in IDLE.
- RECV:
  - o_byte_ready=1, o_busy=1.
  - A byte is accepted on a cycle where i_byte_valid && o_byte_ready.
  - Accepted byte n (byte_cnt=n, 0..3) is written to assembly bits [8n+7:8n] (little-endian: first byte is LSB); byte_cnt increments.
  - On acceptance of the 4th byte (byte_cnt=3), go to WRITE and clear byte_cnt.
  - No acceptance while i_byte_valid=0; the state is held indefinitely.
- WRITE:
  - o_byte_ready=0, o_busy=1.
  - o_mem_we=1 for exactly this one cycle, with o_mem_waddr=word_cnt and o_mem_wdata=assembled word.
  - If word_cnt == count-1, go to DONE; otherwise increment word_cnt and return to RECV.
- Latency and throughput:
  - o_mem_we is asserted in the cycle immediately after the 4th byte handshake.
  - Maximum throughput is 4 bytes per 5 cycles.
- DONE:
  - o_done=1, o_cpu_rst=0, o_busy=0, o_byte_ready=0.
  - i_start is handled exactly as in IDLE. A legal start clears o_done and re-asserts o_cpu_rst on the next cycle.
  - An illegal start pulses o_err and stays in DONE.
- i_start is ignored in RECV and WRITE.
- Bytes presented in IDLE, WRITE or DONE are not accepted (ready=0).
- o_mem_raddr (combinational): equals i_cpu_pc when o_cpu_rst=0; otherwise 0.
- Boundary: a count of 2**ADDR_WIDTH writes addresses 0..2**ADDR_WIDTH-1. word_cnt never wraps, because DONE is entered on the last address.
- o_mem_waddr and o_mem_wdata hold their last values outside WRITE.

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles -> o_cpu_rst=1, o_done=0, o_mem_we=0, o_byte_ready=0, o_mem_raddr=0 with i_cpu_pc=8'h10.
- Single-word load: start, i_num_words=1, bytes 13,00,00,00 back-to-back -> 1-cycle o_mem_we with waddr=0 and wdata=32'h00000013, one cycle after the 4th byte; next cycle o_done=1, o_cpu_rst=0, o_mem_raddr follows i_cpu_pc.
- Multi-word with gaps: i_num_words=3, random valid gaps -> three writes at addresses 0,1,2 with correct little-endian words; ready=0 during each WRITE cycle; no byte lost or duplicated.
- Illegal count: start with i_num_words=0, then with 257 -> o_err pulses once per attempt, state stays IDLE, o_busy=0.
- Full memory: i_num_words=256 -> last write at waddr=8'hFF, then DONE; no write to address 0 after the last.
- Abort and restart: i_rst asserted after 2 words of a 4-word load -> IDLE, o_cpu_rst=1, o_done=0; a new load of 2 words starts at waddr=0 and completes; a start from DONE re-asserts o_cpu_rst.
